mem_stage: RTL and testbench

- Memory-access pipeline stage. It is the consumer of the execute stage's registered outputs and drives the data SRAM through a req/addr_ok/data_ok handshake.
- Holds one instruction. Non-memory instructions pass through in one cycle. Loads and stores stall the stage until the SRAM transaction completes.
- Presents the result to write-back with a valid/allowin handshake, and exports a load-busy flag for the decode-stage hazard logic.

---
 rtl/mem_stage_pkg.sv | 15 +
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths and FSM encoding for the memory-access stage
package mem_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with SRAM req/addr_ok/data_ok handshake
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              exe_valid,
    output logic              mem_allowin,
    input  logic              exe_reg_en,
    input  logic              exe_mem_read,
    input  logic              exe_mem_write,
    input  logic [REG_AW-1:0] exe_reg_waddr,
    input  logic [DATA_W-1:0] exe_alu_result,
    input  logic [DATA_W-1:0] exe_store_data,

    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,

    output logic              mem_valid,
    input  logic              wb_allowin,
    output logic              mem_reg_en,
    output logic [REG_AW-1:0] mem_reg_waddr,
    output logic [DATA_W-1:0] mem_reg_wdata,
    output logic              mem_load_busy
);

    mem_state_t        state;
    logic              stage_valid;
    logic              reg_en_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [REG_AW-1:0] reg_waddr_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] store_q;
    logic [DATA_W-1:0] rdata_q;

    logic ready_go;
    logic accept;

    assign ready_go    = (state == ST_DONE);
    assign mem_allowin = !stage_valid || (ready_go && wb_allowin);
    assign accept      = exe_valid && mem_allowin;

    // Single-instruction holding register and transaction FSM; a new accept
    // overrides the DONE exit so back-to-back hand-off needs no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            stage_valid <= 1'b0;
            reg_en_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_waddr_q <= '0;
            alu_q       <= '0;
            store_q     <= '0;
            rdata_q     <= '0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            reg_en_q    <= exe_reg_en;
            mem_read_q  <= exe_mem_read;
            mem_write_q <= exe_mem_write;
            reg_waddr_q <= exe_reg_waddr;
            alu_q       <= exe_alu_result;
            store_q     <= exe_store_data;
            state       <= (exe_mem_read || exe_mem_write) ? ST_REQ : ST_DONE;
        end else begin
            case (state)
                ST_REQ: begin
                    if (data_addr_ok) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // data_ok is only meaningful here; a stray one elsewhere is dropped.
                    if (data_data_ok) begin
                        state <= ST_DONE;
                        if (mem_read_q) begin
                            rdata_q <= data_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    if (wb_allowin) begin
                        state       <= ST_IDLE;
                        stage_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request fields come straight from the latched payload, so they stay
    // stable for as long as the request is held.
    assign data_req   = (state == ST_REQ);
    assign data_wr    = mem_write_q;
    assign data_addr  = {alu_q[ADDR_W-1:2], 2'b00};
    assign data_wdata = store_q;

    assign mem_valid     = stage_valid && ready_go;
    assign mem_reg_en    = reg_en_q;
    assign mem_reg_waddr = reg_waddr_q;
    assign mem_reg_wdata = mem_read_q ? rdata_q : alu_q;
    assign mem_load_busy = stage_valid && mem_read_q && (state != ST_DONE);

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_valid;
    logic        mem_allowin;
    logic        exe_reg_en;
    logic        exe_mem_read;
    logic        exe_mem_write;
    logic [4:0]  exe_reg_waddr;
    logic [31:0] exe_alu_result;
    logic [31:0] exe_store_data;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_valid;
    logic        wb_allowin;
    logic        mem_reg_en;
    logic [4:0]  mem_reg_waddr;
    logic [31:0] mem_reg_wdata;
    logic        mem_load_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .exe_valid      (exe_valid),
        .mem_allowin    (mem_allowin),
        .exe_reg_en     (exe_reg_en),
        .exe_mem_read   (exe_mem_read),
        .exe_mem_write  (exe_mem_write),
        .exe_reg_waddr  (exe_reg_waddr),
        .exe_alu_result (exe_alu_result),
        .exe_store_data (exe_store_data),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .mem_valid      (mem_valid),
        .wb_allowin     (wb_allowin),
        .mem_reg_en     (mem_reg_en),
        .mem_reg_waddr  (mem_reg_waddr),
        .mem_reg_wdata  (mem_reg_wdata),
        .mem_load_busy  (mem_load_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic rd, input logic wr, input logic en,
                             input logic [4:0] wa, input logic [31:0] alu,
                             input logic [31:0] sd);
        exe_valid      = 1'b1;
        exe_mem_read   = rd;
        exe_mem_write  = wr;
        exe_reg_en     = en;
        exe_reg_waddr  = wa;
        exe_alu_result = alu;
        exe_store_data = sd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        exe_valid = 1'b0; exe_reg_en = 1'b0; exe_mem_read = 1'b0; exe_mem_write = 1'b0;
        exe_reg_waddr = '0; exe_alu_result = '0; exe_store_data = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        wb_allowin = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_req",      32'(data_req), 32'd0);
        chk("rst_valid",    32'(mem_valid), 32'd0);
        chk("rst_busy",     32'(mem_load_busy), 32'd0);
        chk("rst_allowin",  32'(mem_allowin), 32'd1);
        chk("rst_reg_en",   32'(mem_reg_en), 32'd0);
        chk("rst_wdata",    mem_reg_wdata, 32'h0);
        reset = 1'b0;

        // non-memory instruction
        set_instr(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0);
        #1 chk("alu_allowin", 32'(mem_allowin), 32'd1);
        @(negedge clk);
        exe_valid = 1'b0;
        chk("alu_valid", 32'(mem_valid), 32'd1);
        chk("alu_wdata", mem_reg_wdata, 32'h1234);
        chk("alu_waddr", 32'(mem_reg_waddr), 32'd5);
        chk("alu_reg_en", 32'(mem_reg_en), 32'd1);
        chk("alu_req", 32'(data_req), 32'd0);
        @(negedge clk);
        chk("alu_drain", 32'(mem_valid), 32'd0);

        // load: addr_ok in first REQ cycle, data_ok two cycles later
        set_instr(1'b1, 1'b0, 1'b1, 5'd7, 32'h1003, 32'h0);
        @(negedge clk);
        exe_valid = 1'b0;
        chk("ld_req", 32'(data_req), 32'd1);
        chk("ld_addr", data_addr, 32'h1000);
        chk("ld_wr", 32'(data_wr), 32'd0);
        chk("ld_busy_req", 32'(mem_load_busy), 32'd1);
        chk("ld_allowin", 32'(mem_allowin), 32'd0);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("ld_req_drop", 32'(data_req), 32'd0);
        chk("ld_busy_wait", 32'(mem_load_busy), 32'd1);
        chk("ld_valid_wait", 32'(mem_valid), 32'd0);
        @(negedge clk);
        chk("ld_busy_wait2", 32'(mem_load_busy), 32'd1);
        data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        @(negedge clk);
        data_data_ok = 1'b0; data_rdata = 32'h0;
        chk("ld_valid", 32'(mem_valid), 32'd1);
        chk("ld_wdata", mem_reg_wdata, 32'hDEADBEEF);
        chk("ld_waddr", 32'(mem_reg_waddr), 32'd7);
        chk("ld_busy_done", 32'(mem_load_busy), 32'd0);
        @(negedge clk);
        chk("ld_drain", 32'(mem_valid), 32'd0);

        // store with addr_ok delayed: request held four cycles
        set_instr(1'b0, 1'b1, 1'b0, 5'd0, 32'h20, 32'hA5A5A5A5);
        @(negedge clk);
        exe_valid = 1'b0; exe_alu_result = 32'hFFFF_FFFF; exe_store_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk("st_req", 32'(data_req), 32'd1);
            chk("st_addr", data_addr, 32'h20);
            chk("st_wdata", data_wdata, 32'hA5A5A5A5);
            chk("st_wr", 32'(data_wr), 32'd1);
            chk("st_allowin", 32'(mem_allowin), 32'd0);
            chk("st_valid_req", 32'(mem_valid), 32'd0);
            data_addr_ok = (i == 3);
            @(negedge clk);
        end
        data_addr_ok = 1'b0;
        chk("st_req_drop", 32'(data_req), 32'd0);
        chk("st_valid_wait", 32'(mem_valid), 32'd0);
        chk("st_allowin_wait", 32'(mem_allowin), 32'd0);
        data_data_ok = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("st_valid", 32'(mem_valid), 32'd1);
        chk("st_reg_en", 32'(mem_reg_en), 32'd0);
        chk("st_wdata_res", mem_reg_wdata, 32'h20);
        @(negedge clk);

        // write-back back-pressure on a completed load
        wb_allowin = 1'b0;
        set_instr(1'b1, 1'b0, 1'b1, 5'd9, 32'h40, 32'h0);
        @(negedge clk);
        exe_valid = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h55AA1234;
        @(negedge clk);
        data_data_ok = 1'b0; data_rdata = 32'h0;
        set_instr(1'b0, 1'b0, 1'b1, 5'd3, 32'h777, 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk("bp_valid", 32'(mem_valid), 32'd1);
            chk("bp_wdata", mem_reg_wdata, 32'h55AA1234);
            chk("bp_waddr", 32'(mem_reg_waddr), 32'd9);
            chk("bp_allowin", 32'(mem_allowin), 32'd0);
            @(negedge clk);
        end
        wb_allowin = 1'b1;
        #1 chk("bp_release", 32'(mem_allowin), 32'd1);
        @(negedge clk);
        exe_valid = 1'b0;
        chk("bp_next_valid", 32'(mem_valid), 32'd1);
        chk("bp_next_wdata", mem_reg_wdata, 32'h777);
        chk("bp_next_waddr", 32'(mem_reg_waddr), 32'd3);
        @(negedge clk);

        // back-to-back non-memory flow
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b0, 1'b0, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h0);
            #1 chk("b2b_allowin", 32'(mem_allowin), 32'd1);
            @(negedge clk);
            chk("b2b_valid", 32'(mem_valid), 32'd1);
            chk("b2b_wdata", mem_reg_wdata, 32'h100 + 32'(i));
            chk("b2b_waddr", 32'(mem_reg_waddr), 32'(i + 1));
        end
        exe_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drain", 32'(mem_valid), 32'd0);

        // reset during WAIT, stray data_ok afterwards
        set_instr(1'b1, 1'b0, 1'b1, 5'd11, 32'h80, 32'h0);
        @(negedge clk);
        exe_valid = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("rmid_busy", 32'(mem_load_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rmid_valid", 32'(mem_valid), 32'd0);
        chk("rmid_allowin", 32'(mem_allowin), 32'd1);
        chk("rmid_busy_clr", 32'(mem_load_busy), 32'd0);
        chk("rmid_req", 32'(data_req), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        data_data_ok = 1'b0; data_rdata = 32'h0;
        chk("stray_valid", 32'(mem_valid), 32'd0);
        chk("stray_req", 32'(data_req), 32'd0);
        chk("stray_allowin", 32'(mem_allowin), 32'd1);
        @(negedge clk);
        chk("stray_valid2", 32'(mem_valid), 32'd0);
        chk("stray_wdata", mem_reg_wdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
